// File: rtl/pc_stack.sv
// pc_stack
//   Program counter with an integrated circular return-address stack, in
//   the style of the 4004 call/return scheme. The PC advances once per
//   instruction fetch (on the INC_CYCLE machine cycle). It also loads jump
//   targets, and it pushes or pops return addresses for subroutine call and
//   return. The stack level and the sticky overflow/underflow flags are
//   exported for decode and debug.
//
// Parameters
//   ADDR_W     PC and stack-entry width (>= 4)
//   DEPTH      number of return-address stack entries (>= 1)
//   INC_CYCLE  machine-cycle code (0..7) on which the PC increments
//   LVL_W      width of stkLevel (derived, not overridable)
//
// Ports
//   clk         system clock; all state changes on the rising edge
//   rstN        asynchronous active-low reset
//   cycle       machine cycle code 0:A1 1:A2 2:A3 3:M1 4:M2 5:X1 6:X2 7:X3
//   pcLoad      jump: PC <= pcLoadData
//   pcCall      call: push the current PC, then PC <= pcLoadData
//   pcRet       return: PC <= popped entry
//   pcLoadData  jump/call target
//   clrFlags    synchronous clear of stkOvf/stkUnf
//   pcAddr      current PC (registered)
//   stkTop      entry that a pop would return right now
//   stkLevel    number of valid entries, 0..DEPTH
//   stkOvf      sticky: a push happened while the stack was full
//   stkUnf      sticky: a pop happened while the stack was empty

module pc_stack #(
  parameter  int ADDR_W    = 12,
  parameter  int DEPTH     = 3,
  parameter  int INC_CYCLE = 2,
  localparam int LVL_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic [2:0]        cycle,
  input  logic              pcLoad,
  input  logic              pcCall,
  input  logic              pcRet,
  input  logic [ADDR_W-1:0] pcLoadData,
  input  logic              clrFlags,
  output logic [ADDR_W-1:0] pcAddr,
  output logic [ADDR_W-1:0] stkTop,
  output logic [LVL_W-1:0]  stkLevel,
  output logic              stkOvf,
  output logic              stkUnf
);

  // A single-entry stack still needs a 1-bit pointer so the declarations
  // remain legal; the pointer simply never leaves zero in that case.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
  localparam logic [2:0]       INC_CODE  = 3'(INC_CYCLE);

  // Stack storage and write pointer. ptr addresses the next slot to be
  // written; the most recent push sits one slot below it (circularly).
  logic [ADDR_W-1:0] stack_mem [DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_up;
  logic [PTR_W-1:0]  ptr_down;

  // Decoded actions for this edge. At most one of these is set.
  logic do_ret;
  logic do_call;
  logic do_load;
  logic do_inc;

  // Next-state values.
  logic [ADDR_W-1:0] pc_next;
  logic [PTR_W-1:0]  ptr_next;
  logic [LVL_W-1:0]  level_next;
  logic              set_ovf;
  logic              set_unf;
  logic              ovf_next;
  logic              unf_next;

  // Circular pointer neighbours. These are computed with explicit wrap
  // compares so that DEPTH does not have to be a power of two.
  always_comb begin
    ptr_up   = (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    ptr_down = (ptr == '0) ? PTR_LAST : ptr - PTR_W'(1);
  end

  // The entry a return would pop is always the slot just below the write
  // pointer. During underflow this slot holds a stale value, and that
  // stale value is deliberately exposed.
  always_comb begin
    stkTop = stack_mem[ptr_down];
  end

  // Priority decode: return > call > jump > fetch increment. An op that is
  // asserted on the increment cycle suppresses the increment for that edge.
  always_comb begin
    do_ret  = pcRet;
    do_call = pcCall & ~pcRet;
    do_load = pcLoad & ~pcCall & ~pcRet;
    do_inc  = ~pcLoad & ~pcCall & ~pcRet & (cycle == INC_CODE);
  end

  // Next PC selection.
  always_comb begin
    pc_next = pcAddr;
    if (do_ret) begin
      pc_next = stkTop;
    end else if (do_call || do_load) begin
      pc_next = pcLoadData;
    end else if (do_inc) begin
      pc_next = pcAddr + ADDR_W'(1);
    end
  end

  // Pointer and level bookkeeping. The pointer always moves on a push or a
  // pop, even when the level saturates. This is what makes an overflowing
  // push overwrite the oldest entry, and an underflowing pop walk back
  // through stale entries.
  always_comb begin
    ptr_next   = ptr;
    level_next = stkLevel;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    if (do_ret) begin
      ptr_next = ptr_down;
      if (stkLevel == '0) begin
        set_unf = 1'b1;
      end else begin
        level_next = stkLevel - LVL_W'(1);
      end
    end else if (do_call) begin
      ptr_next = ptr_up;
      if (stkLevel == LVL_FULL) begin
        set_ovf = 1'b1;
      end else begin
        level_next = stkLevel + LVL_W'(1);
      end
    end
  end

  // Sticky flags. A new event on the same edge as clrFlags keeps the flag
  // set, so an error is never lost to a clear that races it.
  always_comb begin
    ovf_next = set_ovf | (stkOvf & ~clrFlags);
    unf_next = set_unf | (stkUnf & ~clrFlags);
  end

  // PC, pointer, level and flag registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pcAddr   <= '0;
      ptr      <= '0;
      stkLevel <= '0;
      stkOvf   <= 1'b0;
      stkUnf   <= 1'b0;
    end else begin
      pcAddr   <= pc_next;
      ptr      <= ptr_next;
      stkLevel <= level_next;
      stkOvf   <= ovf_next;
      stkUnf   <= unf_next;
    end
  end

  // Stack storage. A call stores the PC as it stands before this edge,
  // which is already past the fetched instruction words, so a later
  // return resumes at the right place without any +1 adjustment.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) begin
        stack_mem[i] <= '0;
      end
    end else if (do_call) begin
      stack_mem[ptr] <= pcAddr;
    end
  end

endmodule
